cond_unit: RTL
==============

Name: cond_unit

Overview:
- Consumer end of the ALU flag interface in the multicycle ARM datapath.
- Holds the architectural NZCV register and captures ALU flags when a flag-setting instruction's ALU result arrives.
- Evaluates the 4-bit ARM condition field of each issued instruction against the current flags, forwarding in-flight flags where needed.
- Gates PCSrc/RegWrite/MemWrite and stalls issue while a flag update is outstanding.

Parameters:
RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset; sampled on rising clk.
instr_valid  in  1  issue stage presents an instruction this cycle.
cond  in  4  instruction condition field.
flag_w  in  2  flag write request: [1] updates N,Z; [0] updates C,V.
pcs  in  1  instruction writes PC.
reg_w  in  1  instruction writes register file.
mem_w  in  1  instruction writes memory.
no_write  in  1  suppresses register write (CMP/CMN/TST/TEQ).
alu_valid  in  1  alu_flags carries the result of the pending flag-setting instruction.
alu_flags  in  4  ALU flags: [3]=N, [2]=Z, [1]=C, [0]=V.
flags  out  4  registered NZCV.
stall  out  1  issue must hold the current instruction.
cond_ex  out  1  condition passed for the presented instruction.
pc_src  out  1  gated pcs.
reg_write  out  1  gated reg_w.
mem_write  out  1  gated mem_w.

Behaviour:
- Reset (reset==0 at posedge):
  - flags=RESET_FLAGS; state=IDLE; pend_mask=2'b00.
  - Outputs are combinational and therefore 0 unless instr_valid.
  - Reset during WAIT discards the pending update.
- States:
  - IDLE: no flag update outstanding.
  - WAIT: holds pend_mask of the flag-setting instruction awaiting alu_valid.
- Effective flags (eff), combinational:
  - In WAIT with alu_valid=1: eff = flags with the pend_mask-selected fields replaced by alu_flags.
  - Otherwise: eff = flags.
- Stall and fire:
  - stall = (state==WAIT) & ~alu_valid, asserted regardless of instr_valid.
  - fire = instr_valid & ~stall.
- Condition evaluation on eff:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C.
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V.
  - 1000 C&~Z; 1001 ~C|Z.
  - 1010 N==V; 1011 N!=V.
  - 1100 ~Z&(N==V); 1101 Z|(N!=V).
  - 1110 1; 1111 0 (reserved, never executes).
- Output gating:
  - cond_ex = instr_valid & eval; it reports the evaluation even while stalled.
  - pc_src = fire & cond_ex & pcs.
  - reg_write = fire & cond_ex & reg_w & ~no_write.
  - mem_write = fire & cond_ex & mem_w.
  - All gated outputs are 0 while stall=1.
- Flag register update at posedge:
  - WAIT & alu_valid: flags <= eff.
  - Any other case: flags unchanged, including alu_valid in IDLE.
  - Within a field pair, the two flags always update together.
- State transitions at posedge:
  - IDLE → WAIT with pend_mask<=flag_w when fire & cond_ex & (flag_w!=0).
  - Otherwise IDLE stays IDLE.
  - WAIT → WAIT while ~alu_valid.
  - WAIT & alu_valid → WAIT with pend_mask<=flag_w if a new instruction fires with cond_ex & flag_w!=0 in the same cycle (back-to-back flag setters, no bubble).
  - WAIT & alu_valid → IDLE otherwise.
- Failed-condition flag setters (cond_ex=0) never update flags and never enter WAIT.
- Latency:
  - Condition result and gating: 0 cycles (combinational).
  - Flag capture: visible on flags 1 cycle after the alu_valid cycle.
  - Forwarded to a dependent instruction in the alu_valid cycle itself.

Test Plan:
- Reset: hold reset=0 two cycles with RESET_FLAGS=4'b0000 → flags=0000, stall=0; then cond=0000 (EQ), instr_valid=1, reg_w=1 → cond_ex=0, reg_write=0.
- Stall and forwarding:
  - cond=1110, flag_w=11, instr_valid=1 → next cycle stall=1.
  - Present cond=0000, reg_w=1 with alu_valid=0 for 2 cycles → reg_write=0, stall=1.
  - Then alu_valid=1, alu_flags=0100 → stall=0, cond_ex=1, reg_write=1; next cycle flags=0100.
- Partial update: flags=1001; flag setter with flag_w=10, alu_flags=0110 → flags=0101 (NZ replaced, CV kept).
- Condition sweep:
  - For eff in {0000, 0100, 1000, 0001, 0010, 1001}, all 16 cond codes → cond_ex matches the table.
  - cond=1111 → cond_ex=0.
  - Failed flag setter (cond=0001 with Z=1, flag_w=11) → no WAIT, flags unchanged.
- Back-to-back:
  - In the WAIT & alu_valid cycle, fire a second setter with flag_w=01 → state stays WAIT with pend_mask=01.
  - alu_flags captured for the first setter; the second setter's flags are captured at its own alu_valid.
- Reset mid-WAIT: reset=0 while in WAIT with alu_valid=1, alu_flags=1111 → flags=RESET_FLAGS, state IDLE, stall=0 next cycle.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: ARM condition unit for the multicycle datapath.
// Holds the architectural NZCV register and evaluates each issued
// instruction's condition field against it. Flags arriving from the ALU
// are forwarded in the cycle they arrive. Issue stalls while a
// flag-setting instruction is still waiting for its ALU result.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [3:0] cond,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       alu_valid,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       stall,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pendMask_q, pendMask_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] effFlags;
    logic       evalPass;
    logic       fire;
    logic       newSetter;
    logic       flagN, flagZ, flagC, flagV;

    // Effective flags: the stored NZCV with the pending fields replaced by the ALU result in the cycle it arrives.
    always_comb begin
        effFlags = flags_q;
        if (state_q == WAIT && alu_valid) begin
            if (pendMask_q[1]) begin
                effFlags[3:2] = alu_flags[3:2];
            end
            if (pendMask_q[0]) begin
                effFlags[1:0] = alu_flags[1:0];
            end
        end
    end

    assign flagN = effFlags[3];
    assign flagZ = effFlags[2];
    assign flagC = effFlags[1];
    assign flagV = effFlags[0];

    // Decode the ARM condition field against the effective flags; 1111 is reserved and never executes.
    always_comb begin
        evalPass = 1'b0;
        unique case (cond)
            4'b0000: evalPass = flagZ;
            4'b0001: evalPass = ~flagZ;
            4'b0010: evalPass = flagC;
            4'b0011: evalPass = ~flagC;
            4'b0100: evalPass = flagN;
            4'b0101: evalPass = ~flagN;
            4'b0110: evalPass = flagV;
            4'b0111: evalPass = ~flagV;
            4'b1000: evalPass = flagC & ~flagZ;
            4'b1001: evalPass = ~flagC | flagZ;
            4'b1010: evalPass = (flagN == flagV);
            4'b1011: evalPass = (flagN != flagV);
            4'b1100: evalPass = ~flagZ & (flagN == flagV);
            4'b1101: evalPass = flagZ | (flagN != flagV);
            4'b1110: evalPass = 1'b1;
            4'b1111: evalPass = 1'b0;
            default: evalPass = 1'b0;
        endcase
    end

    assign stall     = (state_q == WAIT) & ~alu_valid;
    assign fire      = instr_valid & ~stall;
    assign cond_ex   = instr_valid & evalPass;
    assign pc_src    = fire & cond_ex & pcs;
    assign reg_write = fire & cond_ex & reg_w & ~no_write;
    assign mem_write = fire & cond_ex & mem_w;
    assign newSetter = fire & cond_ex & (flag_w != 2'b00);
    assign flags     = flags_q;

    // Next-state logic: commit forwarded flags when the ALU result lands and start a new wait for each passing flag setter.
    always_comb begin
        state_d    = state_q;
        pendMask_d = pendMask_q;
        flags_d    = flags_q;
        unique case (state_q)
            IDLE: begin
                if (newSetter) begin
                    state_d    = WAIT;
                    pendMask_d = flag_w;
                end
            end
            WAIT: begin
                if (alu_valid) begin
                    flags_d = effFlags;
                    if (newSetter) begin
                        state_d    = WAIT;
                        pendMask_d = flag_w;
                    end else begin
                        state_d    = IDLE;
                        pendMask_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                pendMask_d = 2'b00;
            end
        endcase
    end

    // State and flag registers with synchronous active-low reset that also drops any pending update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pendMask_q <= 2'b00;
            flags_q    <= RESET_FLAGS;
        end else begin
            state_q    <= state_d;
            pendMask_q <= pendMask_d;
            flags_q    <= flags_d;
        end
    end

endmodule
